// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker
//   Receive-side monitor for a binary up/down counter stream. It locks onto
//   the observed sequence and flags every step that is not a legal +/-1
//   (modulo 2^WIDTH) transition in the direction given by i_mode. A
//   saturating counter keeps the number of flagged steps.
//
//   Optional build macro: CNT_SEQ_CHECKER_HOLD_EN
//     When it is defined, a sample equal to the previous one (a counter with
//     its enable low) is tolerated. It neither advances nor breaks lock.
//     When it is undefined, a repeated value is an ordinary mismatch.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_valid    a count sample is present this cycle
//   i_mode     direction that produced i_cnt (0 = up, 1 = down)
//   i_cnt      observed count value
//   i_clr      synchronous clear of o_err_cnt (has no effect on the FSM)
//   o_locked   checker is tracking a valid sequence
//   o_err      one-cycle pulse: illegal step seen while locked
//   o_err_cnt  saturating count of o_err pulses
//   o_expected next value predicted from the last accepted sample and mode
module cnt_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int LOCK_LEN = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [WIDTH-1:0] o_expected
);

    typedef enum logic [1:0] {UNSYNC, SYNC, LOCK} state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [4:0]       LOCK_TH = 5'(LOCK_LEN);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [3:0]       good, good_nxt;
    logic [4:0]       good_inc;
    logic [WIDTH-1:0] exp_val;
    logic             match;
    logic             hold;
    logic             err_nxt;

    // Prediction from the last accepted sample. The current sample's mode
    // is used, so a direction change is legal on its very first sample.
    assign exp_val  = i_mode ? (prev - ONE) : (prev + ONE);
    assign match    = (i_cnt == exp_val);
    assign good_inc = {1'b0, good} + 5'd1;

`ifdef CNT_SEQ_CHECKER_HOLD_EN
    assign hold = (i_cnt == prev);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        good_nxt  = good;
        err_nxt   = 1'b0;
        if (i_valid) begin
            // Every accepted sample re-anchors, including an offending one.
            prev_nxt = i_cnt;
            case (state)
                UNSYNC: begin
                    good_nxt  = 4'd0;
                    state_nxt = SYNC;
                end
                SYNC: begin
                    if (hold) begin
                        good_nxt = good;
                    end else if (match) begin
                        good_nxt = good_inc[3:0];
                        if (good_inc == LOCK_TH)
                            state_nxt = LOCK;
                    end else begin
                        good_nxt = 4'd0;
                    end
                end
                LOCK: begin
                    if (!(hold || match)) begin
                        err_nxt   = 1'b1;
                        good_nxt  = 4'd0;
                        state_nxt = SYNC;
                    end
                end
                default: state_nxt = UNSYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= UNSYNC;
            prev  <= '0;
            good  <= 4'd0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
            good  <= good_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
            o_expected <= '0;
        end else begin
            o_locked <= (state_nxt == LOCK);
            o_err    <= err_nxt;
            if (i_valid)
                o_expected <= i_mode ? (i_cnt - ONE) : (i_cnt + ONE);
        end
    end

    // Clear has priority over a coincident error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_err_cnt <= '0;
        else if (i_clr)
            o_err_cnt <= '0;
        else if (err_nxt && (o_err_cnt != ERR_MAX))
            o_err_cnt <= o_err_cnt + ERR_W'(1);
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
module tb_cnt_seq_checker;

    localparam int LOCK_LEN = 2;
`ifdef CNT_SEQ_CHECKER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic       clr = 1'b0;

    logic       locked, err;
    logic [7:0] err_cnt;
    logic [3:0] expv;
    logic       locked2, err2;
    logic [1:0] err_cnt2;
    logic [3:0] expv2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the stream looks like, not how the RTL is built.
    bit m_have;    // a sample has been seen since reset
    bit m_locked;
    bit m_err;
    int m_streak;  // consecutive legal steps since the last break
    int m_prev;
    int m_exp;
    int m_ecnt;    // saturates at 255
    int m_ecnt2;   // saturates at 3

    cnt_seq_checker #(.WIDTH(4), .ERR_W(8), .LOCK_LEN(LOCK_LEN)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mode(mode),
        .i_cnt(cnt), .i_clr(clr), .o_locked(locked), .o_err(err),
        .o_err_cnt(err_cnt), .o_expected(expv)
    );

    cnt_seq_checker #(.WIDTH(4), .ERR_W(2), .LOCK_LEN(LOCK_LEN)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mode(mode),
        .i_cnt(cnt), .i_clr(clr), .o_locked(locked2), .o_err(err2),
        .o_err_cnt(err_cnt2), .o_expected(expv2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_err = 0; m_streak = 0;
        m_prev = 0; m_exp = 0; m_ecnt = 0; m_ecnt2 = 0;
    endtask

    task automatic model_edge(input bit v, input bit md, input int c, input bit cl);
        int e;
        m_err = 0;
        if (v) begin
            e = md ? (m_prev + 15) % 16 : (m_prev + 1) % 16;
            if (!m_have) begin
                m_have = 1; m_streak = 0;
            end else if (HOLD && c == m_prev) begin
                // tolerated repeat: nothing changes
            end else if (c == e) begin
                if (!m_locked) begin
                    m_streak++;
                    if (m_streak == LOCK_LEN) m_locked = 1;
                end
            end else begin
                if (m_locked) m_err = 1;
                m_locked = 0; m_streak = 0;
            end
            m_prev = c;
            m_exp  = md ? (c + 15) % 16 : (c + 1) % 16;
        end
        if (cl) begin
            m_ecnt = 0; m_ecnt2 = 0;
        end else if (m_err) begin
            if (m_ecnt < 255) m_ecnt++;
            if (m_ecnt2 < 3) m_ecnt2++;
        end
    endtask

    // Drive one cycle; outputs are stable 1 ns after the edge on return.
    task automatic step(input bit v, input bit md, input int c, input bit cl);
        valid = v; mode = md; cnt = 4'(c); clr = cl;
        @(posedge clk);
        if (rst_n) model_edge(v, md, c & 15, cl);
        #1;
    endtask

    // Asynchronous reset pulse between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #10;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0d want 0", locked); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        n_cmp++; if (expv !== 4'd0) begin n_bad++; $display("FAIL reset_expected: got %0d want 0", expv); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_up_run();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, i, 0);
            n_cmp++; if (locked !== (i >= 2)) begin n_bad++; $display("FAIL uprun_locked[%0d]: got %0d want %0d", i, locked, i >= 2); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL uprun_err[%0d]: got %0d want 0", i, err); end
            if (i == 2) begin
                n_cmp++; if (expv !== 4'd3) begin n_bad++; $display("FAIL uprun_expected: got %0d want 3", expv); end
            end
        end
    endtask

    task automatic test_wrap_dir();
        int vals[8] = '{13, 14, 15, 0, 1, 0, 15, 14};
        bit mds[8]  = '{0, 0, 0, 0, 0, 1, 1, 1};
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, mds[i], vals[i], 0);
            n_cmp++; if (locked !== (i >= 2)) begin n_bad++; $display("FAIL wrap_locked[%0d]: got %0d want %0d", i, locked, i >= 2); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wrap_err[%0d]: got %0d want 0", i, err); end
        end
        n_cmp++; if (expv !== 4'd13) begin n_bad++; $display("FAIL wrap_expected: got %0d want 13", expv); end
    endtask

    task automatic test_glitch();
        int vals[8]   = '{4, 5, 6, 0, 1, 2, 3, 4};
        bit wlock[8]  = '{0, 0, 1, 0, 0, 1, 1, 1};
        bit werr[8]   = '{0, 0, 0, 1, 0, 0, 0, 0};
        int wcnt[8]   = '{0, 0, 0, 1, 1, 1, 1, 1};
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, vals[i], 0);
            n_cmp++; if (locked !== wlock[i]) begin n_bad++; $display("FAIL glitch_locked[%0d]: got %0d want %0d", i, locked, wlock[i]); end
            n_cmp++; if (err !== werr[i]) begin n_bad++; $display("FAIL glitch_err[%0d]: got %0d want %0d", i, err, werr[i]); end
            n_cmp++; if (err_cnt !== 8'(wcnt[i])) begin n_bad++; $display("FAIL glitch_errcnt[%0d]: got %0d want %0d", i, err_cnt, wcnt[i]); end
        end
        // err must be a single-cycle pulse: idle cycle afterwards stays low
        step(0, 0, 0, 0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL glitch_idle_err: got %0d want 0", err); end
    endtask

    task automatic test_saturation();
        int p;
        pulse_reset();
        step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 2, 0);
        p = 2;
        for (int k = 1; k <= 5; k++) begin
            p = (p + 5) % 16;
            step(1, 0, p, 0);
            n_cmp++; if (err_cnt2 !== 2'((k > 3) ? 3 : k)) begin n_bad++; $display("FAIL sat_errcnt2[%0d]: got %0d want %0d", k, err_cnt2, (k > 3) ? 3 : k); end
            n_cmp++; if (err_cnt !== 8'(k)) begin n_bad++; $display("FAIL sat_errcnt8[%0d]: got %0d want %0d", k, err_cnt, k); end
            p = (p + 1) % 16; step(1, 0, p, 0);
            p = (p + 1) % 16; step(1, 0, p, 0);
        end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_relocked: got %0d want 1", locked); end
        // sixth error coincides with clear: clear wins
        p = (p + 5) % 16;
        step(1, 0, p, 1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sat_clr_err: got %0d want 1", err); end
        n_cmp++; if (err_cnt2 !== 2'd0) begin n_bad++; $display("FAIL sat_clr_errcnt2: got %0d want 0", err_cnt2); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sat_clr_errcnt8: got %0d want 0", err_cnt); end
    endtask

    task automatic test_hold();
        pulse_reset();
        step(1, 0, 5, 0); step(1, 0, 6, 0); step(1, 0, 7, 0);
        step(1, 0, 7, 0);
        n_cmp++; if (err !== !HOLD) begin n_bad++; $display("FAIL hold_err: got %0d want %0d", err, !HOLD); end
        n_cmp++; if (locked !== HOLD) begin n_bad++; $display("FAIL hold_locked: got %0d want %0d", locked, HOLD); end
        n_cmp++; if (err_cnt !== (HOLD ? 8'd0 : 8'd1)) begin n_bad++; $display("FAIL hold_errcnt: got %0d want %0d", err_cnt, HOLD ? 0 : 1); end
        step(1, 0, 8, 0);
        n_cmp++; if (locked !== HOLD) begin n_bad++; $display("FAIL hold_next_locked: got %0d want %0d", locked, HOLD); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hold_next_err: got %0d want 0", err); end
    endtask

    task automatic test_gaps_async();
        pulse_reset();
        step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 0);
            n_cmp++; if (locked !== 1'b1 || err !== 1'b0 || expv !== 4'd3) begin
                n_bad++; $display("FAIL gap_hold[%0d]: got locked=%0d err=%0d exp=%0d want 1/0/3", i, locked, err, expv);
            end
        end
        step(1, 0, 3, 0);
        n_cmp++; if (locked !== 1'b1 || err !== 1'b0 || expv !== 4'd4) begin
            n_bad++; $display("FAIL gap_resume: got locked=%0d err=%0d exp=%0d want 1/0/4", locked, err, expv);
        end
        step(1, 0, 9, 0); step(1, 0, 10, 0); step(1, 0, 11, 0);
        n_cmp++; if (err_cnt !== 8'd1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL gap_pre_async: got errcnt=%0d locked=%0d want 1/1", err_cnt, locked);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0 || expv !== 4'd0) begin
            n_bad++; $display("FAIL async_reset: got locked=%0d err=%0d errcnt=%0d exp=%0d want all 0", locked, err, err_cnt, expv);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int  last = int'($urandom_range(0, 15));
        bit  md = 0;
        bit  v, cl;
        int  c, r;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 9) == 0) md = ~md;
            r = int'($urandom_range(0, 19));
            if (r < 15)      c = md ? (last + 15) % 16 : (last + 1) % 16;
            else if (r < 17) c = last;
            else             c = int'($urandom_range(0, 15));
            cl = ($urandom_range(0, 24) == 0);
            if (v) last = c;
            step(v, md, c, cl);
            n_cmp++; if (locked !== m_locked) begin n_bad++; $display("FAIL rand_locked[%0d]: got %0d want %0d", i, locked, m_locked); end
            n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %0d want %0d", i, err, m_err); end
            n_cmp++; if (err_cnt !== 8'(m_ecnt)) begin n_bad++; $display("FAIL rand_errcnt[%0d]: got %0d want %0d", i, err_cnt, m_ecnt); end
            n_cmp++; if (err_cnt2 !== 2'(m_ecnt2)) begin n_bad++; $display("FAIL rand_errcnt2[%0d]: got %0d want %0d", i, err_cnt2, m_ecnt2); end
            if (m_locked) begin
                n_cmp++; if (expv !== 4'(m_exp)) begin n_bad++; $display("FAIL rand_expected[%0d]: got %0d want %0d", i, expv, m_exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_wrap_dir();
        test_glitch();
        test_saturation();
        test_hold();
        test_gaps_async();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
